// File: rtl/dct_quant_serializer.sv
// dct_quant_serializer
//   Captures one 8x8 block of signed DCT coefficients, quantizes each coefficient with the
//   JPEG luminance table (quality 50) by reciprocal multiplication, and streams the results
//   one per cycle in zig-zag order over a valid/ready handshake.
//
// Ports:
//   clk_in         system clock
//   rst_in         synchronous, active-high reset
//   dct_in         coefficient block [row][col], each DATA_WIDTH-bit two's complement
//   dct_in_valid   one-cycle capture strobe, honoured only while in_ready is high
//   in_ready       a new block can be captured
//   coef_out       quantized coefficient (OUT_WIDTH-bit signed)
//   coef_index     zig-zag index 0..63 of coef_out
//   coef_valid     coef_out / coef_index / coef_last valid
//   coef_last      high with coef_index == 63
//   coef_ready     downstream accepts when coef_valid && coef_ready
//   block_dropped  one-cycle pulse after a dct_in_valid that arrived while busy
module dct_quant_serializer #(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned OUT_WIDTH   = 11,
  parameter int unsigned RECIP_WIDTH = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [7:0][7:0][DATA_WIDTH-1:0]   dct_in,
  input  logic                              dct_in_valid,
  output logic                              in_ready,
  output logic signed [OUT_WIDTH-1:0]       coef_out,
  output logic [5:0]                        coef_index,
  output logic                              coef_valid,
  output logic                              coef_last,
  input  logic                              coef_ready,
  output logic                              block_dropped
);

  localparam int unsigned PW = DATA_WIDTH + RECIP_WIDTH + 1;
  localparam int unsigned QW = PW - RECIP_WIDTH;
  localparam logic [PW-1:0] Half = PW'(1) << (RECIP_WIDTH - 1);

  // Zig-zag index -> raster position (row*8 + col).
  localparam logic [5:0] ZigZag [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // round(2^16 / Q) for the quality-50 luminance table, raster order.
  localparam logic [15:0] RecipRom [64] = '{
    16'd4096, 16'd5958, 16'd6554, 16'd4096, 16'd2731, 16'd1638, 16'd1285, 16'd1074,
    16'd5461, 16'd5461, 16'd4681, 16'd3449, 16'd2521, 16'd1130, 16'd1092, 16'd1192,
    16'd4681, 16'd5041, 16'd4096, 16'd2731, 16'd1638, 16'd1150, 16'd950,  16'd1170,
    16'd4681, 16'd3855, 16'd2979, 16'd2260, 16'd1285, 16'd753,  16'd819,  16'd1057,
    16'd3641, 16'd2979, 16'd1771, 16'd1170, 16'd964,  16'd601,  16'd636,  16'd851,
    16'd2731, 16'd1872, 16'd1192, 16'd1024, 16'd809,  16'd630,  16'd580,  16'd712,
    16'd1337, 16'd1024, 16'd840,  16'd753,  16'd636,  16'd542,  16'd546,  16'd649,
    16'd910,  16'd712,  16'd690,  16'd669,  16'd585,  16'd655,  16'd636,  16'd662
  };

  typedef enum logic {StIdle, StRun} state_e;

  state_e                            state_q;
  logic [6:0]                        k_q;        // next beat to issue; 64 = all issued
  logic [7:0][7:0][DATA_WIDTH-1:0]   blk_q;
  logic                              in_ready_q;
  logic                              valid_q;
  logic                              last_q;
  logic signed [OUT_WIDTH-1:0]       coef_q;
  logic [5:0]                        index_q;
  logic                              dropped_q;

  logic [5:0]                        pos;
  logic [DATA_WIDTH-1:0]             x;
  logic [DATA_WIDTH-1:0]             mag;
  logic                              x_neg;
  logic [RECIP_WIDTH-1:0]            recip;
  logic [PW-1:0]                     prod;
  logic [QW-1:0]                     qmag;
  logic signed [QW:0]                qsig;
  logic signed [OUT_WIDTH-1:0]       coef_nx;
  logic                              load;
  logic                              accept;

  // Quantize the coefficient addressed by k_q: round half away from zero on the magnitude.
  always_comb begin
    pos     = ZigZag[k_q[5:0]];
    x       = blk_q[pos[5:3]][pos[2:0]];
    x_neg   = x[DATA_WIDTH-1];
    mag     = x_neg ? -x : x;  // -(-2^(W-1)) is still correct read as unsigned
    recip   = RECIP_WIDTH'(RecipRom[pos]);
    prod    = PW'(mag) * PW'(recip) + Half;
    qmag    = prod[PW-1:RECIP_WIDTH];
    qsig    = x_neg ? -$signed({1'b0, qmag}) : $signed({1'b0, qmag});
    coef_nx = OUT_WIDTH'(qsig);
  end

  assign accept = valid_q && coef_ready;
  // Output register refills when empty or when its beat leaves this cycle.
  assign load   = (state_q == StRun) && !k_q[6] && (!valid_q || coef_ready);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      k_q        <= '0;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      coef_q     <= '0;
      index_q    <= '0;
      dropped_q  <= 1'b0;
    end else begin
      dropped_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dct_in_valid) begin
            blk_q      <= dct_in;
            k_q        <= '0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
          end
        end
        StRun: begin
          if (dct_in_valid) dropped_q <= 1'b1;
          if (load) begin
            coef_q  <= coef_nx;
            index_q <= k_q[5:0];
            last_q  <= (k_q[5:0] == 6'd63);
            valid_q <= 1'b1;
            k_q     <= k_q + 7'd1;
          end else if (accept) begin
            valid_q <= 1'b0;
          end
          if (accept && last_q) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign coef_out      = coef_q;
  assign coef_index    = index_q;
  assign coef_valid    = valid_q;
  assign coef_last     = last_q;
  assign block_dropped = dropped_q;

endmodule
